// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction fetch stage: holds the fetch PC, reads the instruction memory,
//   handles branch redirects (with a one-cycle IF/ID flush) and halts fetch
//   on a misaligned redirect until reset.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   reset          synchronous active-high reset
//   PC_Write       1 = advance PC by 4, 0 = hold (load-use stall)
//   Branch_Taken   redirect request from downstream resolution
//   Branch_Target  redirect address, used when Branch_Taken = 1
//   IMEM_WE        program-load write strobe
//   IMEM_Addr      word index for the program-load write
//   IMEM_Data      word written when IMEM_WE = 1
//   PC_Out         registered fetch PC
//   Instruction    word at PC_Out (zero while faulted)
//   Flush          registered, high for the cycle after an accepted redirect
//   Fault          registered, high once a misaligned redirect was seen
//   Fetch_Count    registered count of sequential PC advances since reset
// ----------------------------------------------------------------------------
module if_fetch_stage #(
   parameter int          IMEM_WORDS = 16,
   parameter logic [63:0] RESET_PC   = 64'h0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          PC_Write,
   input  logic                          Branch_Taken,
   input  logic [63:0]                   Branch_Target,
   input  logic                          IMEM_WE,
   input  logic [$clog2(IMEM_WORDS)-1:0] IMEM_Addr,
   input  logic [31:0]                   IMEM_Data,
   output logic [63:0]                   PC_Out,
   output logic [31:0]                   Instruction,
   output logic                          Flush,
   output logic                          Fault,
   output logic [31:0]                   Fetch_Count
);

   localparam int AW = $clog2(IMEM_WORDS);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   // A redirect target must be word aligned; anything else halts fetch.
   function automatic logic is_misaligned(input logic [63:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

   logic [31:0] imem_r [IMEM_WORDS];

   state_t      state_r;
   state_t      state_nxt_s;
   logic [63:0] pc_r;
   logic [63:0] pc_nxt_s;
   logic [31:0] cnt_r;
   logic [31:0] cnt_nxt_s;
   logic        flush_r;
   logic        fault_r;
   logic [31:0] rd_word_s;

   // Program-load write port; deliberately not reset so a loaded image survives reset.
   always_ff @(posedge clk) begin
      if (IMEM_WE) begin
         imem_r[IMEM_Addr] <= IMEM_Data;
      end
   end

   // Next-state, next-PC and next-count decision in priority order.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_RUN, ST_FLUSH: begin
            if (Branch_Taken) begin
               if (is_misaligned(Branch_Target)) begin
                  state_nxt_s = ST_FAULT;
               end else begin
                  // A redirect wins over a stall and never counts as an advance.
                  pc_nxt_s    = Branch_Target;
                  state_nxt_s = ST_FLUSH;
               end
            end else if (PC_Write) begin
               pc_nxt_s    = pc_r + 64'd4;
               cnt_nxt_s   = cnt_r + 32'd1;
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_FAULT: begin
            state_nxt_s = ST_FAULT;
         end
         default: begin
            // Unreachable encoding: fall back to a clean running state.
            state_nxt_s = ST_RUN;
         end
      endcase
   end

   // State, PC, counter and status flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_RUN;
         pc_r    <= RESET_PC;
         cnt_r   <= 32'd0;
         flush_r <= 1'b0;
         fault_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= pc_nxt_s;
         cnt_r   <= cnt_nxt_s;
         // Flags are registered copies of the next state so they track it exactly.
         flush_r <= (state_nxt_s == ST_FLUSH);
         fault_r <= (state_nxt_s == ST_FAULT);
      end
   end

   // Asynchronous read; PC bits above the word index are ignored so fetch wraps.
   always_comb begin
      rd_word_s = imem_r[pc_r[AW+1:2]];
   end

   // Suppress the fetched word while fetch is halted.
   always_comb begin
      if (fault_r) begin
         Instruction = 32'h0;
      end else begin
         Instruction = rd_word_s;
      end
   end

   assign PC_Out      = pc_r;
   assign Flush       = flush_r;
   assign Fault       = fault_r;
   assign Fetch_Count = cnt_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_stage
//   Directed bench for if_fetch_stage (IMEM_WORDS = 16, RESET_PC = 0).
//   Memory image: word 0..3 = 11,22,33,44; word i (i>=4) = 0xA0 + i.
// ----------------------------------------------------------------------------
module tb_if_fetch_stage;

   logic        clk;
   logic        reset;
   logic        PC_Write;
   logic        Branch_Taken;
   logic [63:0] Branch_Target;
   logic        IMEM_WE;
   logic [3:0]  IMEM_Addr;
   logic [31:0] IMEM_Data;
   logic [63:0] PC_Out;
   logic [31:0] Instruction;
   logic        Flush;
   logic        Fault;
   logic [31:0] Fetch_Count;

   int tests_run;
   int tests_failed;

   if_fetch_stage #(.IMEM_WORDS(16), .RESET_PC(64'h0)) dut (
      .clk           (clk),
      .reset         (reset),
      .PC_Write      (PC_Write),
      .Branch_Taken  (Branch_Taken),
      .Branch_Target (Branch_Target),
      .IMEM_WE       (IMEM_WE),
      .IMEM_Addr     (IMEM_Addr),
      .IMEM_Data     (IMEM_Data),
      .PC_Out        (PC_Out),
      .Instruction   (Instruction),
      .Flush         (Flush),
      .Fault         (Fault),
      .Fetch_Count   (Fetch_Count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Check every output at once.
   task automatic chk_all(input string tag, input logic [63:0] pc, input logic [31:0] ins,
                          input logic fl, input logic ft, input logic [31:0] cnt);
      chk({tag, ".pc"},    PC_Out, pc);
      chk({tag, ".instr"}, {32'h0, Instruction}, {32'h0, ins});
      chk({tag, ".flush"}, {63'h0, Flush}, {63'h0, fl});
      chk({tag, ".fault"}, {63'h0, Fault}, {63'h0, ft});
      chk({tag, ".cnt"},   {32'h0, Fetch_Count}, {32'h0, cnt});
   endtask

   initial begin
      logic [31:0] exp_w [4];
      tests_run     = 0;
      tests_failed  = 0;
      reset         = 1'b1;
      PC_Write      = 1'b0;
      Branch_Taken  = 1'b0;
      Branch_Target = 64'h0;
      IMEM_WE       = 1'b0;
      IMEM_Addr     = 4'd0;
      IMEM_Data     = 32'h0;
      exp_w[0] = 32'd11; exp_w[1] = 32'd22; exp_w[2] = 32'd33; exp_w[3] = 32'd44;

      // Program load while reset is held (writes accepted during reset).
      for (int i = 0; i < 16; i++) begin
         IMEM_WE   = 1'b1;
         IMEM_Addr = 4'(i);
         IMEM_Data = (i < 4) ? exp_w[i] : (32'hA0 + 32'(i));
         step();
      end
      IMEM_WE = 1'b0;
      step();
      chk_all("reset", 64'h0, 32'd11, 1'b0, 1'b0, 32'd0);

      // Sequential fetch of four words.
      reset    = 1'b0;
      PC_Write = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("seq.pc", PC_Out, 64'(4 * k));
         chk("seq.instr", {32'h0, Instruction}, {32'h0, exp_w[k]});
         step();
      end
      chk_all("seq.end", 64'h10, 32'hA4, 1'b0, 1'b0, 32'd4);

      // Reset then advance to PC=8 and stall three cycles.
      reset = 1'b1;
      step();
      chk_all("rst2", 64'h0, 32'd11, 1'b0, 1'b0, 32'd0);
      reset = 1'b0;
      step();
      step();
      PC_Write = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk_all("stall", 64'h8, 32'd33, 1'b0, 1'b0, 32'd2);
      end

      // Reset, advance to PC=4, branch to 0x20 while stalled.
      reset = 1'b1;
      step();
      reset    = 1'b0;
      PC_Write = 1'b1;
      step();
      chk_all("pc4", 64'h4, 32'd22, 1'b0, 1'b0, 32'd1);
      PC_Write      = 1'b0;
      Branch_Taken  = 1'b1;
      Branch_Target = 64'h20;
      step();
      chk_all("br20", 64'h20, 32'hA8, 1'b1, 1'b0, 32'd1);
      Branch_Taken = 1'b0;
      PC_Write     = 1'b1;
      step();
      chk_all("br20.after", 64'h24, 32'hA9, 1'b0, 1'b0, 32'd2);

      // Back-to-back aligned branches 0x10 then 0x30.
      Branch_Taken  = 1'b1;
      Branch_Target = 64'h10;
      step();
      chk_all("b2b.1", 64'h10, 32'hA4, 1'b1, 1'b0, 32'd2);
      Branch_Target = 64'h30;
      step();
      chk_all("b2b.2", 64'h30, 32'hAC, 1'b1, 1'b0, 32'd2);
      Branch_Taken = 1'b0;
      PC_Write     = 1'b0;
      step();
      chk_all("b2b.end", 64'h30, 32'hAC, 1'b0, 1'b0, 32'd2);

      // Wrap-around: branch to 0x3C then advance to 0x40 -> imem[0].
      Branch_Taken  = 1'b1;
      Branch_Target = 64'h3C;
      step();
      chk_all("wrap.3c", 64'h3C, 32'hAF, 1'b1, 1'b0, 32'd2);
      Branch_Taken = 1'b0;
      PC_Write     = 1'b1;
      step();
      chk_all("wrap.40", 64'h40, 32'd11, 1'b0, 1'b0, 32'd3);

      // Misaligned redirect -> FAULT, frozen under further branches.
      Branch_Taken  = 1'b1;
      Branch_Target = 64'h22;
      step();
      chk_all("fault", 64'h40, 32'h0, 1'b0, 1'b1, 32'd3);
      Branch_Target = 64'h80;
      for (int k = 0; k < 5; k++) begin
         step();
         chk_all("fault.hold", 64'h40, 32'h0, 1'b0, 1'b1, 32'd3);
      end
      reset = 1'b1;
      step();
      chk_all("fault.rst", 64'h0, 32'd11, 1'b0, 1'b0, 32'd0);

      // Reset mid-FLUSH overrides a simultaneous branch.
      reset         = 1'b0;
      Branch_Target = 64'h20;
      step();
      chk("midflush.flush", {63'h0, Flush}, 64'h1);
      reset         = 1'b1;
      Branch_Target = 64'h10;
      step();
      chk_all("midflush.rst", 64'h0, 32'd11, 1'b0, 1'b0, 32'd0);

      // Write to the word being read: old value until the edge, new after.
      reset        = 1'b0;
      Branch_Taken = 1'b0;
      PC_Write     = 1'b0;
      IMEM_WE      = 1'b1;
      IMEM_Addr    = 4'd0;
      IMEM_Data    = 32'hDEAD_BEEF;
      #1;
      chk("rdw.old", {32'h0, Instruction}, {32'h0, 32'd11});
      step();
      IMEM_WE = 1'b0;
      chk_all("rdw.new", 64'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);

      // 64-bit PC wrap from the top of the address space.
      Branch_Taken  = 1'b1;
      Branch_Target = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      chk_all("pcwrap.top", 64'hFFFF_FFFF_FFFF_FFFC, 32'hAF, 1'b1, 1'b0, 32'd0);
      Branch_Taken = 1'b0;
      PC_Write     = 1'b1;
      step();
      chk_all("pcwrap.zero", 64'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter IMEM_WORDS, default 16: instruction memory depth in 32-bit words (power of two, 4..256).
REQ-002 Parameter RESET_PC, default 64'h0: PC value loaded on reset (word aligned).
REQ-003 Port clk  input  1: single clock, all state updates on posedge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port PC_Write  input  1: 1 = advance PC; 0 = hold PC (load-use stall from the hazard unit).
REQ-006 Port Branch_Taken  input  1: taken branch or jump resolved downstream; redirect request.
REQ-007 Port Branch_Target  input  64: redirect address, valid when Branch_Taken=1.
REQ-008 Port IMEM_WE  input  1: instruction memory write strobe (program load).
REQ-009 Port IMEM_Addr  input  log2(IMEM_WORDS): word index for the program-load write.
REQ-010 Port IMEM_Data  input  32: word written on IMEM_WE.
REQ-011 Port PC_Out  output  64: current fetch PC, registered; feeds the IF/ID register.
REQ-012 Port Instruction  output  32: word fetched at PC_Out; feeds the IF/ID register.
REQ-013 Port Flush  output  1: registered, clears the IF/ID register for wrong-path removal.
REQ-014 Port Fault  output  1: registered, misaligned redirect detected; fetch halted.
REQ-015 Port Fetch_Count  output  32: registered count of PC advances since reset.

Function
REQ-016 State machine states: RUN, FLUSH, FAULT; encoding is free.
REQ-017 Next-state priority, highest first: reset, FAULT hold, misaligned branch, aligned branch, stall, sequential advance.
REQ-018 RUN, Branch_Taken=1, Branch_Target[1:0]!=0: PC unchanged, next state FAULT, Fault=1 from next cycle.
REQ-019 RUN, Branch_Taken=1, aligned target: PC<=Branch_Target regardless of PC_Write, next state FLUSH.
REQ-020 RUN, no branch, PC_Write=0: PC, Fetch_Count unchanged.
REQ-021 RUN, no branch, PC_Write=1: PC<=PC+4 (64-bit, wraps at 2^64), Fetch_Count<=Fetch_Count+1 (wraps at 2^32).
REQ-022 Flush SHALL be 1 exactly while in FLUSH, i.e. the single cycle after an accepted aligned redirect.
REQ-023 FLUSH: PC advances per REQ-020/021 (branch-target fetch proceeds); a further aligned branch re-enters FLUSH with new target; misaligned branch enters FAULT; otherwise return to RUN.
REQ-024 Branch redirects SHALL NOT increment Fetch_Count.
REQ-025 FAULT: PC, Fetch_Count frozen, Branch_Taken and PC_Write ignored, Fault=1, Flush=0; exit only via reset.
REQ-026 Instruction SHALL be combinational read imem[PC_Out[k+1:2]], k=log2(IMEM_WORDS); PC bits above index are ignored (address wrap-around).
REQ-027 Instruction SHALL be 32'h0 while in FAULT.
REQ-028 IMEM_WE=1 writes IMEM_Data to imem[IMEM_Addr] at posedge; a read of the same word in the same cycle returns the old value; the write is accepted in every state, including during reset.
REQ-029 imem contents are not cleared by reset; uninitialised words read as 0 in simulation.

Reset
REQ-030 reset=1 at posedge: PC_Out<=RESET_PC, Fetch_Count<=0, Flush<=0, Fault<=0, state<=RUN; overrides Branch_Taken and PC_Write in the same cycle.
REQ-031 reset asserted mid-FLUSH or in FAULT SHALL return to RUN at RESET_PC the next cycle with Flush=0, Fault=0.

Verification
REQ-032 Load imem[0..3]=11,22,33,44; reset; PC_Write=1 for 4 cycles -> PC_Out 0,4,8,12, Instruction 11,22,33,44, Fetch_Count=4.
REQ-033 At PC=8, PC_Write=0 for 3 cycles -> PC_Out stays 8, Instruction stays 33, Fetch_Count unchanged, Flush=0.
REQ-034 At PC=4, Branch_Taken=1, Branch_Target=0x20, PC_Write=0 -> next cycle PC_Out=0x20, Flush=1 one cycle, Fetch_Count unchanged.
REQ-035 Branch_Taken=1, Branch_Target=0x22 -> Fault=1, Instruction=0, PC frozen for 5 cycles under further branches; then reset -> PC_Out=0, Fault=0.
REQ-036 IMEM_WORDS=16, PC advances from 0x3C -> PC_Out=0x40, Instruction=imem[0] (wrap-around).
REQ-037 Back-to-back aligned branches to 0x10 then 0x30 -> Flush=1 two consecutive cycles, PC_Out 0x10 then 0x30.
